// File: rtl/red_pitaya_limit_pkg.sv
// rtl/red_pitaya_limit_pkg.sv - register map, rail flag type and reset helpers for the limiter
package red_pitaya_limit_pkg;

    typedef enum logic [4:0] {
        REG_MIN  = 5'h00,
        REG_MAX  = 5'h04,
        REG_STEP = 5'h08,
        REG_STAT = 5'h0C,
        REG_CNTL = 5'h10,
        REG_CNTU = 5'h14
    } reg_off_e;

    typedef struct packed {
        logic upper;
        logic lower;
    } rail_t;

    localparam logic [19:0] REG_CTRL  = 20'h00100;
    localparam int unsigned CH_SHIFT  = 5;
    localparam int unsigned CH_STRIDE = 32'd1 << CH_SHIFT;

    function automatic logic [31:0] rst_min(input int unsigned dw);
        return ~((32'd1 << (dw - 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] rst_max(input int unsigned dw);
        return (32'd1 << (dw - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/red_pitaya_limit_slew_block.sv
// rtl/red_pitaya_limit_slew_block.sv - per-channel clamp, slew limiter, sticky rail flags and counters
module red_pitaya_limit_slew_block
    import red_pitaya_limit_pkg::*;
#(
    parameter int DW   = 14,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [DW-1:0]   dat_i,
    input  logic [DW-1:0]   cfg_min_i,
    input  logic [DW-1:0]   cfg_max_i,
    input  logic [DW-2:0]   cfg_step_i,
    input  logic            stat_clr_i,
    input  logic            cnt_clr_i,
    output logic [DW-1:0]   dat_o,
    output rail_t           railed_o,
    output rail_t           sticky_o,
    output logic [CNTW-1:0] cnt_l_o,
    output logic [CNTW-1:0] cnt_u_o
);

    logic [DW-1:0]   tgt_q, tgt_d, y_q, y_d;
    rail_t           flag_q, flag_d, railed_q, railed_d, sticky_q, sticky_d;
    logic [CNTW-1:0] cnt_l_q, cnt_l_d, cnt_u_q, cnt_u_d;
    logic [DW:0]     diff, mag;

    always_comb begin
        tgt_d  = dat_i;
        flag_d = '0;
        // lower test first so a min>max misconfiguration resolves to min
        if ($signed(dat_i) < $signed(cfg_min_i)) begin
            tgt_d        = cfg_min_i;
            flag_d.lower = 1'b1;
        end else if ($signed(dat_i) > $signed(cfg_max_i)) begin
            tgt_d        = cfg_max_i;
            flag_d.upper = 1'b1;
        end

        diff = {tgt_q[DW-1], tgt_q} - {y_q[DW-1], y_q};
        mag  = diff[DW] ? -diff : diff;
        y_d  = tgt_q;
        if ((cfg_step_i != '0) && (mag > {2'b00, cfg_step_i})) begin
            y_d = diff[DW] ? (y_q - {1'b0, cfg_step_i}) : (y_q + {1'b0, cfg_step_i});
        end
        railed_d = flag_q;

        // clears first, so a rail event in the same cycle still lands
        sticky_d = (stat_clr_i || cnt_clr_i) ? '0 : sticky_q;
        sticky_d = sticky_d | flag_q;
        cnt_l_d  = cnt_clr_i ? '0 : cnt_l_q;
        cnt_u_d  = cnt_clr_i ? '0 : cnt_u_q;
        if (flag_q.lower && (cnt_l_d != '1)) cnt_l_d = cnt_l_d + CNTW'(1);
        if (flag_q.upper && (cnt_u_d != '1)) cnt_u_d = cnt_u_d + CNTW'(1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tgt_q    <= '0;
            flag_q   <= '0;
            y_q      <= '0;
            railed_q <= '0;
            sticky_q <= '0;
            cnt_l_q  <= '0;
            cnt_u_q  <= '0;
        end else begin
            tgt_q    <= tgt_d;
            flag_q   <= flag_d;
            y_q      <= y_d;
            railed_q <= railed_d;
            sticky_q <= sticky_d;
            cnt_l_q  <= cnt_l_d;
            cnt_u_q  <= cnt_u_d;
        end
    end

    assign dat_o    = y_q;
    assign railed_o = railed_q;
    assign sticky_o = sticky_q;
    assign cnt_l_o  = cnt_l_q;
    assign cnt_u_o  = cnt_u_q;

endmodule

// File: rtl/red_pitaya_limit_nch.sv
// rtl/red_pitaya_limit_nch.sv - N-channel limiter top: config register file, bus decode, channel array
module red_pitaya_limit_nch
    import red_pitaya_limit_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int DW   = 14,
    parameter int CNTW = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NCH*DW-1:0] dat_i,
    output logic [NCH*DW-1:0] dat_o,
    output logic [2*NCH-1:0]  railed_o,
    input  logic [31:0]       sys_addr,
    input  logic [31:0]       sys_wdata,
    input  logic              sys_wen,
    input  logic              sys_ren,
    output logic [31:0]       sys_rdata,
    output logic              sys_err,
    output logic              sys_ack
);

    localparam logic [31:0] RST_MIN = rst_min(DW);
    localparam logic [31:0] RST_MAX = rst_max(DW);
    localparam int          CHW     = 20 - CH_SHIFT;

    logic [DW-1:0]   min_q  [NCH];
    logic [DW-1:0]   min_d  [NCH];
    logic [DW-1:0]   max_q  [NCH];
    logic [DW-1:0]   max_d  [NCH];
    logic [DW-2:0]   step_q [NCH];
    logic [DW-2:0]   step_d [NCH];
    rail_t           sticky [NCH];
    logic [CNTW-1:0] cnt_l  [NCH];
    logic [CNTW-1:0] cnt_u  [NCH];
    logic [NCH-1:0]  ch_hit, stat_clr;
    logic            ctrl_hit, cnt_clr, ack_q, ack_d;
    logic [31:0]     rd_val, rdata_q, rdata_d;
    reg_off_e        off;
    logic            bus_unused;

    assign off        = reg_off_e'(sys_addr[CH_SHIFT-1:0]);
    assign ctrl_hit   = (sys_addr[19:0] == REG_CTRL);
    assign cnt_clr    = sys_wen && ctrl_hit && sys_wdata[0];
    assign bus_unused = ^{sys_addr[31:20], sys_wdata[31:DW]};

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_hit[k]   = !ctrl_hit && (sys_addr[19:CH_SHIFT] == CHW'(k));
            min_d[k]    = min_q[k];
            max_d[k]    = max_q[k];
            step_d[k]   = step_q[k];
            stat_clr[k] = 1'b0;
            if (sys_wen && ch_hit[k]) begin
                case (off)
                    REG_MIN:  min_d[k]    = sys_wdata[DW-1:0];
                    REG_MAX:  max_d[k]    = sys_wdata[DW-1:0];
                    REG_STEP: step_d[k]   = sys_wdata[DW-2:0];
                    REG_STAT: stat_clr[k] = 1'b1;
                    default:  ;
                endcase
            end
            if (ch_hit[k]) begin
                case (off)
                    REG_MIN:  rd_val = {{(32-DW){min_q[k][DW-1]}}, min_q[k]};
                    REG_MAX:  rd_val = {{(32-DW){max_q[k][DW-1]}}, max_q[k]};
                    REG_STEP: rd_val = 32'(step_q[k]);
                    REG_STAT: rd_val = 32'(sticky[k]);
                    REG_CNTL: rd_val = 32'(cnt_l[k]);
                    REG_CNTU: rd_val = 32'(cnt_u[k]);
                    default:  rd_val = '0;
                endcase
            end
        end
        rdata_d = sys_ren ? rd_val : '0;
        ack_d   = sys_wen | sys_ren;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < NCH; k++) begin
                min_q[k]  <= RST_MIN[DW-1:0];
                max_q[k]  <= RST_MAX[DW-1:0];
                step_q[k] <= '0;
            end
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                min_q[k]  <= min_d[k];
                max_q[k]  <= max_d[k];
                step_q[k] <= step_d[k];
            end
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        red_pitaya_limit_slew_block #(.DW(DW), .CNTW(CNTW)) u_slew (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .dat_i      (dat_i[k*DW +: DW]),
            .cfg_min_i  (min_q[k]),
            .cfg_max_i  (max_q[k]),
            .cfg_step_i (step_q[k]),
            .stat_clr_i (stat_clr[k]),
            .cnt_clr_i  (cnt_clr),
            .dat_o      (dat_o[k*DW +: DW]),
            .railed_o   (railed_o[2*k +: 2]),
            .sticky_o   (sticky[k]),
            .cnt_l_o    (cnt_l[k]),
            .cnt_u_o    (cnt_u[k])
        );
    end

    assign sys_ack   = ack_q;
    assign sys_rdata = rdata_q;
    assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_limit_nch.sv
// tb/tb_red_pitaya_limit_nch.sv - scoreboard bench for the N-channel limiter against an integer model
module tb_red_pitaya_limit_nch;

    localparam int NCH  = 2;
    localparam int DW   = 14;
    localparam int CNTW = 4;
    localparam int VMAX = (1 << (DW - 1)) - 1;
    localparam int VMIN = -(1 << (DW - 1));
    localparam int CMAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic [NCH*DW-1:0] dat;
        logic [2*NCH-1:0]  railed;
        logic              ack;
        logic              rd;
        logic [31:0]       rdata;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH*DW-1:0] dat_i, dat_o;
    logic [2*NCH-1:0]  railed;
    logic [31:0]       addr, wdata, rdata;
    logic              wen, ren, err, ack;
    int                din [NCH];

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    int m_min [NCH], m_max [NCH], m_step [NCH], m_pt [NCH], m_y [NCH];
    int m_pl [NCH], m_pu [NCH], m_rl [NCH], m_ru [NCH];
    int m_sl [NCH], m_su [NCH], m_cl [NCH], m_cu [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_din
        assign dat_i[k*DW +: DW] = din[k][DW-1:0];
    end

    always #5 clk = ~clk;

    red_pitaya_limit_nch #(.NCH(NCH), .DW(DW), .CNTW(CNTW)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .dat_i     (dat_i),
        .dat_o     (dat_o),
        .railed_o  (railed),
        .sys_addr  (addr),
        .sys_wdata (wdata),
        .sys_wen   (wen),
        .sys_ren   (ren),
        .sys_rdata (rdata),
        .sys_err   (err),
        .sys_ack   (ack)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sx(input logic [31:0] w);
        int v;
        v = int'(w[DW-1:0]);
        if (v > VMAX) v = v - (1 << DW);
        return v;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int ch, off;
        ch  = int'(a[19:5]);
        off = int'(a[4:0]);
        if (a[19:0] == 20'h100 || ch >= NCH) return 32'h0;
        case (off)
            'h00: return 32'(m_min[ch]);
            'h04: return 32'(m_max[ch]);
            'h08: return 32'(m_step[ch]);
            'h0C: return 32'(m_su[ch] * 2 + m_sl[ch]);
            'h10: return 32'(m_cl[ch]);
            'h14: return 32'(m_cu[ch]);
            default: return 32'h0;
        endcase
    endfunction

    // One clock of the reference: outputs, flags and config all advance from pre-edge values.
    task automatic model_edge();
        exp_t e;
        int   ch, off, d, x;
        e = '0;
        if (!rstn) begin
            for (int k = 0; k < NCH; k++) begin
                m_min[k] = VMIN; m_max[k] = VMAX; m_step[k] = 0;
                m_pt[k] = 0; m_y[k] = 0; m_pl[k] = 0; m_pu[k] = 0; m_rl[k] = 0; m_ru[k] = 0;
                m_sl[k] = 0; m_su[k] = 0; m_cl[k] = 0; m_cu[k] = 0;
            end
            exp_q.push_back(e);
            return;
        end
        e.ack = wen | ren;
        e.rd  = ren;
        if (ren) e.rdata = model_read(addr);
        ch  = int'(addr[19:5]);
        off = int'(addr[4:0]);
        if (wen && addr[19:0] == 20'h100) begin
            if (wdata[0]) begin
                for (int k = 0; k < NCH; k++) begin
                    m_sl[k] = 0; m_su[k] = 0; m_cl[k] = 0; m_cu[k] = 0;
                end
            end
        end else if (wen && ch < NCH && off == 'h0C) begin
            m_sl[ch] = 0; m_su[ch] = 0;
        end
        for (int k = 0; k < NCH; k++) begin
            if (m_pl[k] != 0) begin m_sl[k] = 1; if (m_cl[k] < CMAX) m_cl[k]++; end
            if (m_pu[k] != 0) begin m_su[k] = 1; if (m_cu[k] < CMAX) m_cu[k]++; end
            d = m_pt[k] - m_y[k];
            if (m_step[k] == 0 || (d < 0 ? -d : d) <= m_step[k]) m_y[k] = m_pt[k];
            else if (d > 0) m_y[k] = m_y[k] + m_step[k];
            else m_y[k] = m_y[k] - m_step[k];
            m_rl[k] = m_pl[k];
            m_ru[k] = m_pu[k];
            x = din[k];
            m_pl[k] = 0; m_pu[k] = 0;
            if (x < m_min[k]) begin m_pt[k] = m_min[k]; m_pl[k] = 1; end
            else if (x > m_max[k]) begin m_pt[k] = m_max[k]; m_pu[k] = 1; end
            else m_pt[k] = x;
            e.dat[k*DW +: DW]  = m_y[k][DW-1:0];
            e.railed[2*k]      = (m_rl[k] != 0);
            e.railed[2*k+1]    = (m_ru[k] != 0);
        end
        if (wen && addr[19:0] != 20'h100 && ch < NCH) begin
            case (off)
                'h00: m_min[ch]  = sx(wdata);
                'h04: m_max[ch]  = sx(wdata);
                'h08: m_step[ch] = int'(wdata) & VMAX;
                default: ;
            endcase
        end
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dat_o", 64'(dat_o), 64'(e.dat));
            chk("railed_o", 64'(railed), 64'(e.railed));
            chk("sys_ack", 64'(ack), 64'(e.ack));
            chk("sys_err", 64'(err), 64'(0));
            if (e.rd) chk("sys_rdata", 64'(rdata), 64'(e.rdata));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; ren = 1'b1;
        @(negedge clk);
        ren = 1'b0;
    endtask

    task automatic rd_all();
        for (int c = 0; c < NCH; c++) begin
            for (int r = 0; r < 6; r++) rd(32'(c * 32 + r * 4));
        end
    endtask

    initial begin
        addr = '0; wdata = '0; wen = 1'b0; ren = 1'b0; rstn = 1'b0;
        for (int k = 0; k < NCH; k++) din[k] = 0;
        idle(3);
        rstn = 1'b1;
        idle(1);

        rd_all();
        rd(32'h100); rd(32'h18); rd(32'h40);

        wr(32'h00, 32'(-100)); wr(32'h04, 32'd100);
        din[0] = 500;  idle(1);
        din[0] = -500; idle(1);
        din[0] = 0;    idle(3);
        rd(32'h14); rd(32'h10); rd(32'h0C);

        wr(32'h00, 32'(VMIN)); wr(32'h04, 32'(VMAX)); wr(32'h08, 32'd10);
        idle(3);
        din[0] = 35; idle(6);

        wr(32'h04, 32'd100);
        din[0] = 500; idle(3);
        wr(32'h0C, 32'h0); rd(32'h0C);
        din[0] = 0; idle(3);
        wr(32'h0C, 32'h0); rd(32'h0C);

        wr(32'h08, 32'd0); wr(32'h20, 32'(-100));
        din[0] = 500; din[1] = -500; idle(20);
        rd(32'h10); rd(32'h14); rd(32'h30); rd(32'h34);
        din[0] = 0; din[1] = 0; idle(3);
        wr(32'h100, 32'h1);
        rd_all();

        for (int i = 0; i < 300; i++) begin
            int op, ch;
            op = int'($urandom_range(0, 99));
            ch = int'($urandom_range(0, NCH - 1));
            for (int k = 0; k < NCH; k++)
                din[k] = ($urandom_range(0, 3) == 0) ? sx($urandom()) : int'($urandom_range(0, 600)) - 300;
            if (op < 4)       wr(32'(ch * 32), 32'(int'($urandom_range(0, 500)) - 300));
            else if (op < 8)  wr(32'(ch * 32 + 4), 32'(int'($urandom_range(0, 500)) - 200));
            else if (op < 11) wr(32'(ch * 32 + 8), ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 60)));
            else if (op < 13) wr(32'(ch * 32 + 12), $urandom());
            else if (op < 14) wr(32'h100, $urandom());
            else if (op < 26) rd(32'(ch * 32 + 4 * int'($urandom_range(0, 6))));
            else              idle(1);
        end

        wr(32'h00, 32'(-100)); wr(32'h04, 32'd100); wr(32'h08, 32'd0);
        din[0] = 500; idle(3);
        chk("pre_reset_dat", 64'(dat_o[DW-1:0]), 64'(100));
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_dat", 64'(dat_o), 64'(0));
        chk("async_rst_railed", 64'(railed), 64'(0));
        chk("async_rst_ack", 64'(ack), 64'(0));
        idle(2);
        rstn = 1'b1;
        din[0] = 0;
        idle(1);
        rd_all();
        idle(3);
        chk("scoreboard_drained", 64'(exp_q.size() <= 1), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
